// File: rtl/jesd204_tx_frame_sequencer.sv
// JESD204 TX link-layer sequencer: WAIT -> CGS -> ILAS -> DATA, with per-octet eof/somf/eomf markers.
// Latency: all outputs registered; markers for beat n appear one cycle after beat_cnt=n. No backpressure.
// Optional: define JESD204_TX_SEQ_RESYNC_CNT_EN to add the saturating resync_count output.
module jesd204_tx_frame_sequencer #(
    parameter int DATA_PATH_WIDTH  = 4,
    parameter int ILAS_MULTIFRAMES = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       sync_n,
    input  logic                       lmfc_edge,
    input  logic [7:0]                 cfg_octets_per_frame,
    input  logic [7:0]                 cfg_beats_per_multiframe,
    output logic [1:0]                 state,
    output logic [DATA_PATH_WIDTH-1:0] eof,
    output logic [DATA_PATH_WIDTH-1:0] somf,
    output logic [DATA_PATH_WIDTH-1:0] eomf,
    output logic [3:0]                 ilas_mf_index,
    output logic                       char_replace_en,
    output logic                       data_start
`ifdef JESD204_TX_SEQ_RESYNC_CNT_EN
    ,
    output logic [7:0]                 resync_count
`endif
);

    localparam logic [8:0] DPW       = 9'(DATA_PATH_WIDTH);
    localparam logic [3:0] ILAS_LAST = 4'(ILAS_MULTIFRAMES - 1);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_CGS  = 2'd1,
        ST_ILAS = 2'd2,
        ST_DATA = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [7:0]                 beat_cnt_q, beat_cnt_d;
    logic [8:0]                 frame_pos_q, frame_pos_d;
    logic [3:0]                 ilas_mf_q, ilas_mf_d;
    logic [2:0]                 sync_low_q, sync_low_d;
    logic [DATA_PATH_WIDTH-1:0] eof_q, eof_d;
    logic [DATA_PATH_WIDTH-1:0] somf_q, somf_d;
    logic [DATA_PATH_WIDTH-1:0] eomf_q, eomf_d;
    logic                       char_en_q, char_en_d;
    logic                       data_start_q, data_start_d;

    logic [8:0] frame_len;
    logic       in_link;
    logic       mf_wrap;
    logic       resync;
    logic       mark_ok;

    // v < F + DATA_PATH_WIDTH always holds, so DATA_PATH_WIDTH compare-subtract steps reduce it fully.
    function automatic logic [8:0] mod_frame(input logic [8:0] v, input logic [8:0] f);
        logic [8:0] r;
        r = v;
        for (int k = 0; k < DATA_PATH_WIDTH; k++) begin
            if (r >= f) begin
                r = r - f;
            end
        end
        return r;
    endfunction

    assign frame_len = {1'b0, cfg_octets_per_frame} + 9'd1;
    assign in_link   = (state_q == ST_ILAS) || (state_q == ST_DATA);
    assign mf_wrap   = (beat_cnt_q == cfg_beats_per_multiframe);
    assign resync    = in_link && !sync_n && (sync_low_q == 3'd4);
    assign mark_ok   = in_link && ((state_d == ST_ILAS) || (state_d == ST_DATA));

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        frame_pos_d = frame_pos_q;
        ilas_mf_d   = ilas_mf_q;
        sync_low_d  = 3'd0;

        unique case (state_q)
            ST_WAIT: begin
                if (enable) begin
                    state_d = ST_CGS;
                end
            end
            ST_CGS: begin
                if (sync_n && lmfc_edge) begin
                    state_d     = ST_ILAS;
                    beat_cnt_d  = 8'd0;
                    frame_pos_d = 9'd0;
                    ilas_mf_d   = 4'd0;
                end
            end
            default: begin
                // Free-running multiframe counter; lmfc_edge is deliberately not used to realign here.
                if (mf_wrap) begin
                    beat_cnt_d  = 8'd0;
                    frame_pos_d = 9'd0;
                    if (state_q == ST_ILAS) begin
                        if (ilas_mf_q == ILAS_LAST) begin
                            state_d   = ST_DATA;
                            ilas_mf_d = 4'd0;
                        end else begin
                            ilas_mf_d = ilas_mf_q + 4'd1;
                        end
                    end
                end else begin
                    beat_cnt_d  = beat_cnt_q + 8'd1;
                    frame_pos_d = mod_frame(frame_pos_q + DPW, frame_len);
                end

                if (!sync_n) begin
                    sync_low_d = sync_low_q + 3'd1;
                end

                if (resync) begin
                    state_d     = ST_CGS;
                    beat_cnt_d  = 8'd0;
                    frame_pos_d = 9'd0;
                    ilas_mf_d   = 4'd0;
                    sync_low_d  = 3'd0;
                end
            end
        endcase

        if (!enable) begin
            state_d     = ST_WAIT;
            beat_cnt_d  = 8'd0;
            frame_pos_d = 9'd0;
            ilas_mf_d   = 4'd0;
            sync_low_d  = 3'd0;
        end
    end

    // Markers are gated on both current and next state so they clear in step with leaving ILAS/DATA.
    always_comb begin
        eof_d  = '0;
        somf_d = '0;
        eomf_d = '0;
        if (mark_ok) begin
            for (int i = 0; i < DATA_PATH_WIDTH; i++) begin
                eof_d[i] = (mod_frame(frame_pos_q + 9'(i), frame_len) == (frame_len - 9'd1));
            end
            somf_d[0]                 = (beat_cnt_q == 8'd0);
            eomf_d[DATA_PATH_WIDTH-1] = mf_wrap;
        end
        char_en_d    = (state_d == ST_DATA);
        data_start_d = (state_q == ST_ILAS) && (state_d == ST_DATA);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_WAIT;
            beat_cnt_q   <= 8'd0;
            frame_pos_q  <= 9'd0;
            ilas_mf_q    <= 4'd0;
            sync_low_q   <= 3'd0;
            eof_q        <= '0;
            somf_q       <= '0;
            eomf_q       <= '0;
            char_en_q    <= 1'b0;
            data_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            frame_pos_q  <= frame_pos_d;
            ilas_mf_q    <= ilas_mf_d;
            sync_low_q   <= sync_low_d;
            eof_q        <= eof_d;
            somf_q       <= somf_d;
            eomf_q       <= eomf_d;
            char_en_q    <= char_en_d;
            data_start_q <= data_start_d;
        end
    end

    assign state           = state_q;
    assign eof             = eof_q;
    assign somf            = somf_q;
    assign eomf            = eomf_q;
    assign ilas_mf_index   = ilas_mf_q;
    assign char_replace_en = char_en_q;
    assign data_start      = data_start_q;

`ifdef JESD204_TX_SEQ_RESYNC_CNT_EN
    logic [7:0] resync_cnt_q, resync_cnt_d;

    always_comb begin
        resync_cnt_d = resync_cnt_q;
        if (resync && enable && (resync_cnt_q != 8'hFF)) begin
            resync_cnt_d = resync_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resync_cnt_q <= 8'd0;
        end else begin
            resync_cnt_q <= resync_cnt_d;
        end
    end

    assign resync_count = resync_cnt_q;
`endif

endmodule

// File: tb/tb_jesd204_tx_frame_sequencer.sv
// Directed bench for jesd204_tx_frame_sequencer: DPW=4 and DPW=8 instances share link controls.
module tb_jesd204_tx_frame_sequencer;

    logic       clk = 1'b0;
    logic       reset, enable, sync_n, lmfc_edge;
    logic [7:0] cfg4_f, cfg4_b, cfg8_f, cfg8_b;

    logic [1:0] st4, st8;
    logic [3:0] eof4, somf4, eomf4, idx4;
    logic [7:0] eof8, somf8, eomf8;
    logic [3:0] idx8;
    logic       cre4, ds4, cre8, ds8;
`ifdef JESD204_TX_SEQ_RESYNC_CNT_EN
    logic [7:0] rc4, rc8;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] e4_f3 [0:2];
    logic [7:0] e8_f6 [0:2];

    always #5 clk = ~clk;

    jesd204_tx_frame_sequencer #(.DATA_PATH_WIDTH(4), .ILAS_MULTIFRAMES(4)) u_dut4 (
        .clk(clk), .reset(reset), .enable(enable), .sync_n(sync_n), .lmfc_edge(lmfc_edge),
        .cfg_octets_per_frame(cfg4_f), .cfg_beats_per_multiframe(cfg4_b),
        .state(st4), .eof(eof4), .somf(somf4), .eomf(eomf4), .ilas_mf_index(idx4),
        .char_replace_en(cre4), .data_start(ds4)
`ifdef JESD204_TX_SEQ_RESYNC_CNT_EN
        , .resync_count(rc4)
`endif
    );

    jesd204_tx_frame_sequencer #(.DATA_PATH_WIDTH(8), .ILAS_MULTIFRAMES(4)) u_dut8 (
        .clk(clk), .reset(reset), .enable(enable), .sync_n(sync_n), .lmfc_edge(lmfc_edge),
        .cfg_octets_per_frame(cfg8_f), .cfg_beats_per_multiframe(cfg8_b),
        .state(st8), .eof(eof8), .somf(somf8), .eomf(eomf8), .ilas_mf_index(idx8),
        .char_replace_en(cre8), .data_start(ds8)
`ifdef JESD204_TX_SEQ_RESYNC_CNT_EN
        , .resync_count(rc8)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        // F=3, 4 octets/beat: frame ends at octets 2, 5, 8, 11
        e4_f3[0] = 4'b0100; e4_f3[1] = 4'b0010; e4_f3[2] = 4'b1001;
        // F=6, 8 octets/beat: frame ends at octets 5, 11, 17, 23
        e8_f6[0] = 8'b0010_0000; e8_f6[1] = 8'b0000_1000; e8_f6[2] = 8'b1000_0010;

        reset = 1'b1; enable = 1'b0; sync_n = 1'b0; lmfc_edge = 1'b0;
        cfg4_f = 8'd0; cfg4_b = 8'd3;
        cfg8_f = 8'd5; cfg8_b = 8'd2;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_state", 32'(st4), 32'd0);
        chk("rst_eof", 32'(eof4), 32'd0);
        chk("rst_somf", 32'(somf4), 32'd0);
        chk("rst_eomf", 32'(eomf4), 32'd0);
        chk("rst_idx", 32'(idx4), 32'd0);
        chk("rst_cre", 32'(cre4), 32'd0);
        chk("rst_ds", 32'(ds4), 32'd0);

        enable = 1'b1;
        tick();
        chk("wait_to_cgs", 32'(st4), 32'd1);
        chk("cgs_eof", 32'(eof4), 32'd0);

        sync_n = 1'b1; lmfc_edge = 1'b1;
        tick();
        lmfc_edge = 1'b0;
        chk("ilas_entry", 32'(st4), 32'd2);
        chk("ilas_entry_eof", 32'(eof4), 32'd0);
        chk("ilas_entry_idx", 32'(idx4), 32'd0);
        chk("ilas_entry8_eof", 32'(eof8), 32'd0);

        // DPW=4 F=1 (4 beats/MF) and DPW=8 F=6 (3 beats/MF) run in lockstep here
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k <= 15) begin
                chk($sformatf("a_state_%0d", k), 32'(st4), 32'd2);
                chk($sformatf("a_idx_%0d", k), 32'(idx4), 32'(k / 4));
            end else begin
                chk($sformatf("a_state_%0d", k), 32'(st4), 32'd3);
                chk($sformatf("a_cre_%0d", k), 32'(cre4), 32'd1);
                chk($sformatf("a_ds_%0d", k), 32'(ds4), (k == 16) ? 32'd1 : 32'd0);
            end
            chk($sformatf("a_eof_%0d", k), 32'(eof4), 32'hF);
            chk($sformatf("a_somf_%0d", k), 32'(somf4), ((k - 1) % 4 == 0) ? 32'h1 : 32'h0);
            chk($sformatf("a_eomf_%0d", k), 32'(eomf4), ((k - 1) % 4 == 3) ? 32'h8 : 32'h0);
            chk($sformatf("c_state_%0d", k), 32'(st8), (k <= 11) ? 32'd2 : 32'd3);
            chk($sformatf("c_ds_%0d", k), 32'(ds8), (k == 12) ? 32'd1 : 32'd0);
            chk($sformatf("c_eof_%0d", k), 32'(eof8), 32'(e8_f6[(k - 1) % 3]));
            chk($sformatf("c_somf_%0d", k), 32'(somf8), ((k - 1) % 3 == 0) ? 32'h01 : 32'h00);
            chk($sformatf("c_eomf_%0d", k), 32'(eomf8), ((k - 1) % 3 == 2) ? 32'h80 : 32'h00);
        end

        // DPW=4, F=3, 3 beats per multiframe
        enable = 1'b0; reset = 1'b1; sync_n = 1'b0;
        cfg4_f = 8'd2; cfg4_b = 8'd2;
        tick();
        reset = 1'b0; enable = 1'b1;
        tick();
        chk("b_cgs", 32'(st4), 32'd1);
        sync_n = 1'b1; lmfc_edge = 1'b1;
        tick();
        lmfc_edge = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            tick();
            chk($sformatf("b_state_%0d", k), 32'(st4), (k <= 11) ? 32'd2 : 32'd3);
            chk($sformatf("b_eof_%0d", k), 32'(eof4), 32'(e4_f3[(k - 1) % 3]));
            chk($sformatf("b_somf_%0d", k), 32'(somf4), ((k - 1) % 3 == 0) ? 32'h1 : 32'h0);
            chk($sformatf("b_eomf_%0d", k), 32'(eomf4), ((k - 1) % 3 == 2) ? 32'h8 : 32'h0);
        end

        // Four low cycles are tolerated; the fifth forces a resync
        sync_n = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("short_low_%0d", k), 32'(st4), 32'd3);
        end
        sync_n = 1'b1;
        tick();
        chk("short_low_recover", 32'(st4), 32'd3);
        chk("short_low_cre", 32'(cre4), 32'd1);
        sync_n = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("long_low_%0d", k), 32'(st4), 32'd3);
        end
        tick();
        chk("resync_state", 32'(st4), 32'd1);
        chk("resync_cre", 32'(cre4), 32'd0);
        chk("resync_eof", 32'(eof4), 32'd0);
        chk("resync_somf", 32'(somf4), 32'd0);
        chk("resync_eomf", 32'(eomf4), 32'd0);

        // sync_n released ahead of lmfc_edge: wait for the edge
        sync_n = 1'b1;
        tick();
        chk("cgs_hold_1", 32'(st4), 32'd1);
        tick();
        chk("cgs_hold_2", 32'(st4), 32'd1);
        lmfc_edge = 1'b1;
        tick();
        lmfc_edge = 1'b0;
        chk("cgs_to_ilas", 32'(st4), 32'd2);
        chk("cgs_to_ilas_idx", 32'(idx4), 32'd0);
        chk("cgs_to_ilas_eof", 32'(eof4), 32'd0);
        tick();
        chk("ilas2_eof", 32'(eof4), 32'b0100);
        chk("ilas2_somf", 32'(somf4), 32'h1);
        tick(); tick();
        chk("ilas2_idx", 32'(idx4), 32'd1);
        enable = 1'b0;
        tick();
        chk("dis_state", 32'(st4), 32'd0);
        chk("dis_eof", 32'(eof4), 32'd0);
        chk("dis_somf", 32'(somf4), 32'd0);
        chk("dis_eomf", 32'(eomf4), 32'd0);
        chk("dis_idx", 32'(idx4), 32'd0);
        chk("dis_cre", 32'(cre4), 32'd0);
        chk("dis_ds", 32'(ds4), 32'd0);

`ifdef JESD204_TX_SEQ_RESYNC_CNT_EN
        reset = 1'b1;
        tick();
        reset = 1'b0; enable = 1'b1; sync_n = 1'b1;
        tick();
        lmfc_edge = 1'b1;
        tick();
        lmfc_edge = 1'b0;
        chk("rc_start", 32'(rc4), 32'd0);
        for (int n = 1; n <= 300; n++) begin
            sync_n = 1'b0;
            repeat (5) tick();
            if (n == 1) begin
                chk("rc_first", 32'(rc4), 32'd1);
            end
            sync_n = 1'b1; lmfc_edge = 1'b1;
            tick();
            lmfc_edge = 1'b0;
        end
        chk("rc_sat4", 32'(rc4), 32'd255);
        chk("rc_sat8", 32'(rc8), 32'd255);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rc_reset", 32'(rc4), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
